// File: rtl/bp_fe_pkg.sv
// Shared types for the FE cache-request arbiter: FSM state encoding and requester count.
package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_meta  = 2'd1,
        e_busy  = 2'd2
    } bp_fe_arb_state_e;

    localparam int bp_fe_arb_num_req_gp = 2;

endpackage

// File: rtl/bp_fe_cache_req_arbiter.sv
// Round-robin share of the FE LCE cache-request channel between I-cache miss path (0) and prefetcher (1).
// Latency: request passes through combinationally; the next grant comes 1 cycle after completion.
// Backpressure: only the granted requester sees ready, gated by cache_req_ready_i. Optional watchdog: BP_FE_ARB_TIMEOUT_EN.
module bp_fe_cache_req_arbiter
    import bp_fe_pkg::*;
#(
    parameter int req_width_p      = 64,
    parameter int metadata_width_p = 8,
    parameter int timeout_cycles_p = 1024
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic [bp_fe_arb_num_req_gp*req_width_p-1:0]   req_i,
    input  logic [bp_fe_arb_num_req_gp-1:0]               req_v_i,
    output logic [bp_fe_arb_num_req_gp-1:0]               req_ready_o,
    input  logic [bp_fe_arb_num_req_gp*metadata_width_p-1:0] req_metadata_i,
    input  logic [bp_fe_arb_num_req_gp-1:0]               req_metadata_v_i,
    output logic [bp_fe_arb_num_req_gp-1:0]               req_complete_o,
    output logic [req_width_p-1:0]                        cache_req_o,
    output logic                                          cache_req_v_o,
    input  logic                                          cache_req_ready_i,
    output logic [metadata_width_p-1:0]                   cache_req_metadata_o,
    output logic                                          cache_req_metadata_v_o,
    input  logic                                          cache_req_complete_i,
    output logic                                          timeout_o
);

    bp_fe_arb_state_e state_q, state_d;
    logic rr_ptr_q, rr_ptr_d;
    logic grant_r_q, grant_r_d;
    logic grant;
    logic in_ready;
    logic handshake;

    // Round-robin pointer only breaks ties; a lone requester always wins.
    assign grant    = (req_v_i[0] & req_v_i[1]) ? rr_ptr_q : req_v_i[1];
    assign in_ready = (state_q == e_ready);

    assign cache_req_v_o = in_ready & (|req_v_i);
    assign cache_req_o   = grant ? req_i[req_width_p +: req_width_p]
                                 : req_i[0 +: req_width_p];

    assign req_ready_o = {in_ready & cache_req_ready_i &  grant,
                          in_ready & cache_req_ready_i & ~grant};
    assign handshake   = |(req_v_i & req_ready_o);

    assign cache_req_metadata_o   = grant_r_q ? req_metadata_i[metadata_width_p +: metadata_width_p]
                                              : req_metadata_i[0 +: metadata_width_p];
    assign cache_req_metadata_v_o = (state_q == e_meta) & req_metadata_v_i[grant_r_q];

    assign req_complete_o = (~in_ready & cache_req_complete_i) ? {grant_r_q, ~grant_r_q} : '0;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_r_d = grant_r_q;
        unique case (state_q)
            e_ready: begin
                if (handshake) begin
                    state_d   = e_meta;
                    grant_r_d = grant;
                    rr_ptr_d  = ~grant;
                end
            end
            e_meta: begin
                // An early completion abandons any metadata not yet seen.
                if (cache_req_complete_i) begin
                    state_d = e_ready;
                end else if (req_metadata_v_i[grant_r_q]) begin
                    state_d = e_busy;
                end
            end
            e_busy: begin
                if (cache_req_complete_i) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_ready;
            rr_ptr_q  <= 1'b0;
            grant_r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_r_q <= grant_r_d;
        end
    end

`ifdef BP_FE_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (state_q == e_busy) begin
            if (wd_cnt_q != '1) begin
                wd_cnt_d = wd_cnt_q + 32'd1;
            end
            if (wd_cnt_d == 32'(timeout_cycles_p)) begin
                timeout_d = 1'b1;
            end
        end else if (state_d == e_busy) begin
            wd_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (timeout_cycles_p == 0);
    assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_bp_fe_cache_req_arbiter.sv
// Bench for bp_fe_cache_req_arbiter: directed vector table, corner-case sequences, randomized run vs. a transaction model.
module tb_bp_fe_cache_req_arbiter;

    localparam int W = 64;
    localparam int M = 8;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [2*W-1:0] req_i;
    logic [1:0]    req_v_i;
    logic [1:0]    req_ready_o;
    logic [2*M-1:0] req_metadata_i;
    logic [1:0]    req_metadata_v_i;
    logic [1:0]    req_complete_o;
    logic [W-1:0]  cache_req_o;
    logic          cache_req_v_o;
    logic          cache_req_ready_i;
    logic [M-1:0]  cache_req_metadata_o;
    logic          cache_req_metadata_v_o;
    logic          cache_req_complete_i;
    logic          timeout_o;

    always #5 clk = ~clk;

    bp_fe_cache_req_arbiter #(
        .req_width_p      (W),
        .metadata_width_p (M),
        .timeout_cycles_p (16)
    ) dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .req_i                  (req_i),
        .req_v_i                (req_v_i),
        .req_ready_o            (req_ready_o),
        .req_metadata_i         (req_metadata_i),
        .req_metadata_v_i       (req_metadata_v_i),
        .req_complete_o         (req_complete_o),
        .cache_req_o            (cache_req_o),
        .cache_req_v_o          (cache_req_v_o),
        .cache_req_ready_i      (cache_req_ready_i),
        .cache_req_metadata_o   (cache_req_metadata_o),
        .cache_req_metadata_v_o (cache_req_metadata_v_o),
        .cache_req_complete_i   (cache_req_complete_i),
        .timeout_o              (timeout_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the channel, whether its metadata was seen, who wins a tie next.
    int owner;
    bit meta_seen;
    int pref;

    function automatic int pick();
        if (req_v_i == 2'b11) return pref;
        return req_v_i[1] ? 1 : 0;
    endfunction

    task automatic model_check(input string tag);
        int g;
        logic [1:0] e_rdy, e_cmp;
        logic e_cvld, e_mvld;
        g      = pick();
        e_cvld = (owner < 0) && (req_v_i != 2'b00);
        e_rdy  = ((owner < 0) && cache_req_ready_i) ? (2'b01 << g) : 2'b00;
        e_mvld = (owner >= 0) && !meta_seen && req_metadata_v_i[owner];
        e_cmp  = ((owner >= 0) && cache_req_complete_i) ? (2'b01 << owner) : 2'b00;
        cmp({tag, "_ready"}, 64'(req_ready_o), 64'(e_rdy));
        cmp({tag, "_cvld"}, 64'(cache_req_v_o), 64'(e_cvld));
        if (e_cvld) cmp({tag, "_creq"}, cache_req_o, req_i[g*W +: W]);
        cmp({tag, "_mvld"}, 64'(cache_req_metadata_v_o), 64'(e_mvld));
        if (e_mvld) cmp({tag, "_meta"}, 64'(cache_req_metadata_o), 64'(req_metadata_i[owner*M +: M]));
        cmp({tag, "_cmp"}, 64'(req_complete_o), 64'(e_cmp));
    endtask

    task automatic model_advance();
        int g;
        g = pick();
        if (reset_i) begin
            owner = -1; meta_seen = 0; pref = 0;
        end else if (owner < 0) begin
            if (cache_req_ready_i && req_v_i[g]) begin
                owner = g; meta_seen = 0; pref = 1 - g;
            end
        end else if (cache_req_complete_i) begin
            owner = -1;
        end else if (!meta_seen && req_metadata_v_i[owner]) begin
            meta_seen = 1;
        end
    endtask

    task automatic drive(input bit rst, input bit [1:0] v, input bit crdy, input bit [1:0] mv, input bit cpl);
        reset_i              = rst;
        req_v_i              = v;
        cache_req_ready_i    = crdy;
        req_metadata_v_i     = mv;
        cache_req_complete_i = cpl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    typedef struct {
        bit       rst;
        bit [1:0] v;
        bit       crdy;
        bit [1:0] mv;
        bit       cpl;
        bit [1:0] e_rdy;
        bit       e_cvld;
        bit       e_mvld;
        bit [1:0] e_cmp;
        int       gnt;
    } vec_t;

    vec_t tbl[21];

    initial begin
        int prev_g;
        owner = -1; meta_seen = 0; pref = 0;
        req_i          = {64'hB1B1_2222_3333_4444, 64'hA0A0_5555_6666_7777};
        req_metadata_i = {8'hC3, 8'h5A};
        drive(1, 2'b00, 0, 2'b00, 0);

        // Reset, single requester flow, ignored foreign metadata, stalled channel, early completion.
        tbl[0]  = '{1, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0};
        tbl[1]  = '{0, 2'b01, 1, 2'b00, 0, 2'b01, 1, 0, 2'b00, 0};
        tbl[2]  = '{0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0};
        tbl[3]  = '{0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0};
        tbl[4]  = '{0, 2'b00, 1, 2'b01, 0, 2'b00, 0, 1, 2'b00, 0};
        tbl[5]  = '{0, 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 2'b01, 0};
        tbl[6]  = '{0, 2'b10, 1, 2'b00, 0, 2'b10, 1, 0, 2'b00, 1};
        tbl[7]  = '{0, 2'b00, 1, 2'b01, 0, 2'b00, 0, 0, 2'b00, 1};
        tbl[8]  = '{0, 2'b00, 1, 2'b11, 0, 2'b00, 0, 1, 2'b00, 1};
        tbl[9]  = '{0, 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 2'b10, 1};
        tbl[10] = '{0, 2'b00, 0, 2'b00, 1, 2'b00, 0, 0, 2'b00, 0};
        for (int i = 11; i <= 15; i++)
            tbl[i] = '{0, 2'b11, 0, 2'b00, 0, 2'b00, 1, 0, 2'b00, 0};
        tbl[16] = '{0, 2'b11, 1, 2'b00, 0, 2'b01, 1, 0, 2'b00, 0};
        tbl[17] = '{0, 2'b00, 1, 2'b01, 1, 2'b00, 0, 1, 2'b01, 0};
        tbl[18] = '{0, 2'b11, 1, 2'b00, 0, 2'b10, 1, 0, 2'b00, 1};
        tbl[19] = '{0, 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 2'b10, 1};
        tbl[20] = '{0, 2'b00, 0, 2'b10, 0, 2'b00, 0, 0, 2'b00, 0};

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].crdy, tbl[i].mv, tbl[i].cpl);
            @(negedge clk);
            cmp($sformatf("vec%0d_ready", i), 64'(req_ready_o), 64'(tbl[i].e_rdy));
            cmp($sformatf("vec%0d_cvld", i), 64'(cache_req_v_o), 64'(tbl[i].e_cvld));
            cmp($sformatf("vec%0d_mvld", i), 64'(cache_req_metadata_v_o), 64'(tbl[i].e_mvld));
            cmp($sformatf("vec%0d_cmp", i), 64'(req_complete_o), 64'(tbl[i].e_cmp));
            if (tbl[i].e_cvld)
                cmp($sformatf("vec%0d_creq", i), cache_req_o, req_i[tbl[i].gnt*W +: W]);
            if (tbl[i].e_mvld)
                cmp($sformatf("vec%0d_meta", i), 64'(cache_req_metadata_o), 64'(req_metadata_i[tbl[i].gnt*M +: M]));
            cmp($sformatf("vec%0d_tmo", i), 64'(timeout_o), 64'(0));
            tick();
        end

        // Reset while busy: the later completion is not reported and the pointer is back to 0.
        drive(0, 2'b01, 1, 2'b00, 0); @(negedge clk);
        cmp("rst_busy_hs", 64'(req_ready_o), 64'(2'b01)); tick();
        drive(0, 2'b00, 0, 2'b01, 0); tick();
        drive(1, 2'b00, 0, 2'b00, 0); tick();
        drive(0, 2'b00, 0, 2'b00, 1); @(negedge clk);
        cmp("rst_busy_nocmp", 64'(req_complete_o), 64'(2'b00)); tick();
        drive(0, 2'b11, 1, 2'b00, 0); @(negedge clk);
        cmp("rst_busy_rr0", 64'(req_ready_o), 64'(2'b01)); tick();
        drive(0, 2'b00, 1, 2'b01, 1); @(negedge clk);
        model_check("rst_busy_done"); tick();

        // Both continuously valid: grants alternate and none lands in a completion cycle.
        prev_g = -1;
        for (int k = 0; k < 12; k++) begin
            drive(0, 2'b11, 1, 2'b11, (k % 3) == 2);
            @(negedge clk);
            model_check($sformatf("alt%0d", k));
            if (req_ready_o != 2'b00) begin
                if (prev_g >= 0)
                    cmp($sformatf("alt%0d_turn", k), 64'(req_ready_o[1]), 64'(prev_g == 0));
                prev_g = req_ready_o[1] ? 1 : 0;
            end
            tick();
        end

`ifdef BP_FE_ARB_TIMEOUT_EN
        drive(1, 2'b00, 0, 2'b00, 0); tick();
        drive(0, 2'b01, 1, 2'b00, 0); tick();
        drive(0, 2'b00, 0, 2'b01, 0); tick();
        drive(0, 2'b00, 0, 2'b00, 0);
        for (int k = 0; k < 15; k++) tick();
        @(negedge clk); cmp("tmo_before", 64'(timeout_o), 64'(0)); tick();
        @(negedge clk); cmp("tmo_hit", 64'(timeout_o), 64'(1));
        drive(0, 2'b00, 0, 2'b00, 1); tick();
        drive(0, 2'b00, 0, 2'b00, 0); tick();
        @(negedge clk); cmp("tmo_sticky", 64'(timeout_o), 64'(1));
`endif

        for (int k = 0; k < 3000; k++) begin
            req_i          = {$urandom, $urandom, $urandom, $urandom};
            req_metadata_i = 16'($urandom);
            drive($urandom_range(0, 99) == 0, 2'($urandom), $urandom_range(0, 3) != 0,
                  2'($urandom), $urandom_range(0, 3) == 0);
            @(negedge clk);
            model_check("rnd");
`ifndef BP_FE_ARB_TIMEOUT_EN
            cmp("rnd_tmo", 64'(timeout_o), 64'(0));
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
